// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - VGA timing, playfield geometry, colours and flash state types for the pong renderer
package pong_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [11:0] rgb_t;

  localparam coord_t H_VISIBLE = 10'd640;
  localparam coord_t H_FRONT   = 10'd16;
  localparam coord_t H_SYNC    = 10'd96;
  localparam coord_t H_BACK    = 10'd48;
  localparam coord_t H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam coord_t V_VISIBLE = 10'd480;
  localparam coord_t V_FRONT   = 10'd10;
  localparam coord_t V_SYNC    = 10'd2;
  localparam coord_t V_BACK    = 10'd33;
  localparam coord_t V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_SYNC_FIRST = H_VISIBLE + H_FRONT;
  localparam coord_t H_SYNC_LAST  = H_VISIBLE + H_FRONT + H_SYNC - 10'd1;
  localparam coord_t V_SYNC_FIRST = V_VISIBLE + V_FRONT;
  localparam coord_t V_SYNC_LAST  = V_VISIBLE + V_FRONT + V_SYNC - 10'd1;

  localparam coord_t      WALL         = 10'd10;
  localparam coord_t      PADDLE1_X_LO = 10'd39;
  localparam coord_t      PADDLE1_X_HI = 10'd49;
  localparam coord_t      PADDLE2_X_LO = 10'd590;
  localparam coord_t      PADDLE2_X_HI = 10'd600;
  localparam logic [10:0] PADDLE_LEN   = 11'd50;
  localparam logic [10:0] BALL_SIZE    = 11'd10;

  localparam rgb_t COL_BG     = 12'h000;
  localparam rgb_t COL_BALL   = 12'hFF0;
  localparam rgb_t COL_PADDLE = 12'h0F0;
  localparam rgb_t COL_WALL   = 12'hFFF;
  localparam rgb_t COL_FLASH1 = 12'h800;
  localparam rgb_t COL_FLASH2 = 12'h008;

  localparam logic [4:0] FLASH_FRAMES = 5'd30;

  typedef enum logic [1:0] {
    IDLE,
    FLASH1,
    FLASH2
  } flash_state_t;

  // Inclusive span test done at 11 bits so lo+ext near 1023 cannot wrap to small values.
  function automatic logic in_span(input coord_t pos, input coord_t lo, input logic [10:0] ext);
    logic [10:0] p;
    logic [10:0] l;
    p = {1'b0, pos};
    l = {1'b0, lo};
    return (p >= l) && (p <= l + ext);
  endfunction

endpackage

// File: rtl/pong_pixel_gen_if.sv
// rtl/pong_pixel_gen_if.sv - game-state inputs and video outputs of the pong pixel generator
interface pong_pixel_gen_if;
  import pong_pkg::*;

  coord_t ball_x;
  coord_t ball_y;
  coord_t paddle1_y;
  coord_t paddle2_y;
  logic   miss1;
  logic   miss2;
  logic   hsync;
  logic   vsync;
  rgb_t   rgb;
  logic   video_on;
  logic   frame_tick;

  modport master (
    output ball_x, ball_y, paddle1_y, paddle2_y, miss1, miss2,
    input  hsync, vsync, rgb, video_on, frame_tick
  );

  modport slave (
    input  ball_x, ball_y, paddle1_y, paddle2_y, miss1, miss2,
    output hsync, vsync, rgb, video_on, frame_tick
  );

endinterface

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - 640x480 raster counters, registered sync/video_on and the frame strobe
module vga_sync
  import pong_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  output coord_t h,
  output coord_t v,
  output logic   active,
  output logic   frame_tick,
  output logic   hsync,
  output logic   vsync,
  output logic   video_on
);

  logic h_last;
  logic v_last;

  assign h_last     = (h == H_TOTAL - 10'd1);
  assign v_last     = (v == V_TOTAL - 10'd1);
  assign active     = (h < H_VISIBLE) && (v < V_VISIBLE);
  // Fires on the first blanking line so game logic gets the whole vertical blank.
  assign frame_tick = (h == 10'd0) && (v == V_VISIBLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      h        <= '0;
      v        <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else begin
      h <= h_last ? 10'd0 : h + 10'd1;
      if (h_last) begin
        v <= v_last ? 10'd0 : v + 10'd1;
      end
      hsync    <= !((h >= H_SYNC_FIRST) && (h <= H_SYNC_LAST));
      vsync    <= !((v >= V_SYNC_FIRST) && (v <= V_SYNC_LAST));
      video_on <= active;
    end
  end

endmodule

// File: rtl/pong_pixel_gen.sv
// rtl/pong_pixel_gen.sv - pong renderer: per-frame snapshots, miss flash FSM and colour mux
module pong_pixel_gen
  import pong_pkg::*;
(
  input  logic clk,
  input  logic rst,
  pong_pixel_gen_if.slave bus
);

  coord_t       h;
  coord_t       v;
  logic         active;
  logic         frame_tick;
  coord_t       ball_x_q;
  coord_t       ball_y_q;
  coord_t       paddle1_q;
  coord_t       paddle2_q;
  flash_state_t state;
  logic [4:0]   fc;
  logic         wall;
  logic         pad1;
  logic         pad2;
  logic         ball;
  rgb_t         background;
  rgb_t         pixel;

  vga_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .h          (h),
    .v          (v),
    .active     (active),
    .frame_tick (frame_tick),
    .hsync      (bus.hsync),
    .vsync      (bus.vsync),
    .video_on   (bus.video_on)
  );

  assign bus.frame_tick = frame_tick;

  // Positions are frozen at the frame strobe so a frame never shows two ball positions.
  always_ff @(posedge clk) begin
    if (rst) begin
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      paddle1_q <= '0;
      paddle2_q <= '0;
    end else if (frame_tick) begin
      ball_x_q  <= bus.ball_x;
      ball_y_q  <= bus.ball_y;
      paddle1_q <= bus.paddle1_y;
      paddle2_q <= bus.paddle2_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fc    <= '0;
    end else if (bus.miss1) begin
      state <= FLASH1;
      fc    <= FLASH_FRAMES;
    end else if (bus.miss2) begin
      state <= FLASH2;
      fc    <= FLASH_FRAMES;
    end else if (frame_tick && (state != IDLE)) begin
      if (fc <= 5'd1) begin
        state <= IDLE;
        fc    <= '0;
      end else begin
        fc <= fc - 5'd1;
      end
    end
  end

  assign wall = (h < WALL) || (h >= H_VISIBLE - WALL) ||
                (v < WALL) || (v >= V_VISIBLE - WALL);
  assign pad1 = (h >= PADDLE1_X_LO) && (h <= PADDLE1_X_HI) && in_span(v, paddle1_q, PADDLE_LEN);
  assign pad2 = (h >= PADDLE2_X_LO) && (h <= PADDLE2_X_HI) && in_span(v, paddle2_q, PADDLE_LEN);
  assign ball = in_span(h, ball_x_q, BALL_SIZE - 11'd1) &&
                in_span(v, ball_y_q, BALL_SIZE - 11'd1);

  always_comb begin
    background = COL_BG;
    case (state)
      FLASH1:  background = COL_FLASH1;
      FLASH2:  background = COL_FLASH2;
      default: background = COL_BG;
    endcase
  end

  always_comb begin
    pixel = COL_BG;
    if (active) begin
      if (ball) begin
        pixel = COL_BALL;
      end else if (pad1 || pad2) begin
        pixel = COL_PADDLE;
      end else if (wall) begin
        pixel = COL_WALL;
      end else begin
        pixel = background;
      end
    end
  end

  // Registered alongside hsync/vsync/video_on so all video outputs share one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rgb <= COL_BG;
    end else begin
      bus.rgb <= pixel;
    end
  end

endmodule

// File: tb/tb_pong_pixel_gen.sv
// tb/tb_pong_pixel_gen.sv - directed checks of sync timing, rendering, snapshots and miss flash
module tb_pong_pixel_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #20 clk = ~clk;

  pong_pixel_gen_if bus ();

  pong_pixel_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Raster position the outputs currently show: (ph,pv) is the counter value one cycle ago.
  int hm;
  int vm;
  int ph;
  int pv;
  int cyc;

  always @(posedge clk) begin
    if (rst) begin
      hm  <= 0;
      vm  <= 0;
      ph  <= 0;
      pv  <= 0;
      cyc <= 0;
    end else begin
      ph  <= hm;
      pv  <= vm;
      cyc <= cyc + 1;
      if (hm == 799) begin
        hm <= 0;
        vm <= (vm == 524) ? 0 : vm + 1;
      end else begin
        hm <= hm + 1;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic at_pixel(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ph == x && pv == y) && n < 430000);
    if (!(ph == x && pv == y)) check("pixel_timeout", 0, 1);
  endtask

  task automatic sample(input string tag, input int x, input int y, input int exp);
    at_pixel(x, y);
    check(tag, int'(bus.rgb), exp);
  endtask

  task automatic wait_tick(output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_tick && n < 430000);
    if (!bus.frame_tick) check("tick_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic pulse_miss(input logic m1, input logic m2);
    @(negedge clk);
    bus.miss1 = m1;
    bus.miss2 = m2;
    @(negedge clk);
    bus.miss1 = 1'b0;
    bus.miss2 = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    int t1;
    int t2;

    bus.ball_x    = 10'd319;
    bus.ball_y    = 10'd239;
    bus.paddle1_y = 10'd214;
    bus.paddle2_y = 10'd214;
    bus.miss1     = 1'b0;
    bus.miss2     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_hsync", int'(bus.hsync), 1);
    check("rst_vsync", int'(bus.vsync), 1);
    check("rst_rgb", int'(bus.rgb), 'h000);
    check("rst_video_on", int'(bus.video_on), 0);
    check("rst_frame_tick", int'(bus.frame_tick), 0);
    rst = 1'b0;

    n = 0;
    while (bus.hsync && n < 2000) begin @(negedge clk); n++; end
    check("hsync_fall", cyc, 657);
    t = cyc;
    n = 0;
    while (!bus.hsync && n < 2000) begin @(negedge clk); n++; end
    check("hsync_width", cyc - t, 96);
    n = 0;
    while (bus.hsync && n < 2000) begin @(negedge clk); n++; end
    check("h_period", cyc - t, 800);

    wait_tick(t1);
    check("first_tick", t1, 384000);
    @(negedge clk);
    check("tick_width", int'(bus.frame_tick), 0);

    n = 0;
    while (bus.vsync && n < 430000) begin @(negedge clk); n++; end
    check("vsync_line", pv, 490);
    check("vsync_col", ph, 0);
    t = cyc;
    n = 0;
    while (!bus.vsync && n < 2000) begin @(negedge clk); n++; end
    check("vsync_width", cyc - t, 1600);

    sample("wall_left", 5, 100, 'hFFF);
    sample("background", 300, 100, 'h000);
    check("video_on_visible", int'(bus.video_on), 1);
    sample("blank_rgb", 700, 100, 'h000);
    check("video_on_blank", int'(bus.video_on), 0);
    sample("paddle1", 44, 240, 'h0F0);
    sample("ball", 320, 240, 'hFF0);
    sample("paddle2", 595, 240, 'h0F0);
    bus.ball_x = 10'd40;
    bus.ball_y = 10'd220;

    wait_tick(t2);
    check("tick_period", t2 - t1, 420000);
    sample("ball_over_pad", 45, 225, 'hFF0);
    sample("pad1_below_ball", 44, 240, 'h0F0);
    bus.ball_x    = 10'd100;
    bus.ball_y    = 10'd300;
    bus.paddle1_y = 10'd1020;

    wait_tick(t);
    sample("pad1_high_wall", 44, 5, 'hFFF);
    sample("pad1_high_gone", 44, 240, 'h000);
    bus.ball_x = 10'd400;
    sample("snap_old_pos", 100, 300, 'hFF0);
    sample("snap_new_absent", 400, 300, 'h000);

    wait_tick(t);
    sample("snap_old_gone", 100, 300, 'h000);
    sample("snap_new_pos", 400, 300, 'hFF0);
    pulse_miss(1'b0, 1'b1);
    sample("flash2_start", 300, 400, 'h008);

    for (int i = 1; i <= 30; i++) begin
      wait_tick(t);
      if (i == 29) sample("flash2_last", 300, 100, 'h008);
    end
    sample("flash2_end", 300, 100, 'h000);

    pulse_miss(1'b1, 1'b1);
    sample("both_miss1_wins", 300, 200, 'h800);
    pulse_miss(1'b0, 1'b1);
    sample("restart_flash2", 300, 300, 'h008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
